// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shift/rotate unit moving up to STEP bit positions per clock.
// Define SHIFT_CARRY_EN to add the CARRY_OUT port (last bit shifted or rotated out).
module shift_unit_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               SRC_SEL,
    input  logic [2:0]         ALU_FUN,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic               Shift_Enable,
    input  logic               start,
    output logic               Busy,
    output logic [WIDTH-1:0]   SHIFT_OUT,
`ifdef SHIFT_CARRY_EN
    output logic               CARRY_OUT,
`endif
    output logic               SHIFT_Flag
);

    localparam logic [2:0] OP_LSR = 3'b000;
    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    localparam logic [SHAMT_W-1:0] WIDTH_A = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] STEP_A  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] ONE_A   = SHAMT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_out;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [SHAMT_W-1:0]   w_eff;
    logic [SHAMT_W-1:0]   w_k;
    logic [2:0]           r_fun;
    logic                 r_flag;

    // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH (result fully filled).
    function automatic logic [SHAMT_W-1:0] eff_amt(input logic [2:0] fun,
                                                   input logic [SHAMT_W-1:0] amt);
        case (fun)
            OP_LSR, OP_LSL, OP_ASR: eff_amt = (amt > WIDTH_A) ? WIDTH_A : amt;
            OP_ROR, OP_ROL:         eff_amt = amt % WIDTH_A;
            default:                eff_amt = '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] step_shift(input logic [2:0] fun,
                                                    input logic [WIDTH-1:0] v,
                                                    input logic [SHAMT_W-1:0] k);
        logic signed [WIDTH-1:0] sv;
        logic [2*WIDTH-1:0]      dbl;
        sv  = $signed(v);
        dbl = '0;
        case (fun)
            OP_LSR:  step_shift = v >> k;
            OP_LSL:  step_shift = v << k;
            OP_ASR:  step_shift = $unsigned(sv >>> k);
            OP_ROR: begin
                dbl        = {v, v} >> k;
                step_shift = dbl[WIDTH-1:0];
            end
            OP_ROL: begin
                dbl        = {v, v} << k;
                step_shift = dbl[2*WIDTH-1:WIDTH];
            end
            default: step_shift = v;
        endcase
    endfunction

`ifdef SHIFT_CARRY_EN
    logic r_cy;
    logic r_cy_kill;
    logic w_kill;

    // Bit that leaves the word on the last single-position move of a k-position step.
    function automatic logic step_carry(input logic [2:0] fun,
                                        input logic [WIDTH-1:0] v,
                                        input logic [SHAMT_W-1:0] k);
        logic [WIDTH-1:0] t;
        t          = '0;
        step_carry = 1'b0;
        case (fun)
            OP_LSR, OP_ASR, OP_ROR: begin
                t          = v >> (k - ONE_A);
                step_carry = t[0];
            end
            OP_LSL, OP_ROL: begin
                t          = v << (k - ONE_A);
                step_carry = t[WIDTH-1];
            end
            default: step_carry = 1'b0;
        endcase
    endfunction

    assign w_kill = ((ALU_FUN == OP_LSR) || (ALU_FUN == OP_LSL)) && (SHAMT > WIDTH_A);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_eff       = eff_amt(ALU_FUN, SHAMT);
        w_k         = (r_cnt < STEP_A) ? r_cnt : STEP_A;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (w_eff != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == w_k) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else if (Shift_Enable) begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator / result stage; a disabled cycle holds everything, including a pending flag.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_fun  <= '0;
            r_out  <= '0;
            r_flag <= 1'b0;
`ifdef SHIFT_CARRY_EN
            r_cy      <= 1'b0;
            r_cy_kill <= 1'b0;
            CARRY_OUT <= 1'b0;
`endif
        end else if (Shift_Enable) begin
            r_flag <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= SRC_SEL ? B : A;
                        r_fun <= ALU_FUN;
                        r_cnt <= w_eff;
`ifdef SHIFT_CARRY_EN
                        r_cy      <= 1'b0;
                        r_cy_kill <= w_kill;
`endif
                    end
                end
                S_SHIFT: begin
                    r_acc <= step_shift(r_fun, r_acc, w_k);
                    r_cnt <= r_cnt - w_k;
`ifdef SHIFT_CARRY_EN
                    r_cy  <= step_carry(r_fun, r_acc, w_k);
`endif
                end
                S_DONE: begin
                    r_out <= r_acc;
`ifdef SHIFT_CARRY_EN
                    CARRY_OUT <= r_cy & ~r_cy_kill;
`endif
                end
                default: ;
            endcase
        end
    end

    assign Busy       = (r_state == S_SHIFT);
    assign SHIFT_OUT  = r_out;
    assign SHIFT_Flag = r_flag & Shift_Enable;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed scoreboard bench for shift_unit_seq (STEP=1 main instance, STEP=2 companion).
module tb_shift_unit_seq;

    localparam logic [2:0] LSR = 3'b000;
    localparam logic [2:0] LSL = 3'b001;
    localparam logic [2:0] ASR = 3'b010;
    localparam logic [2:0] ROR = 3'b011;
    localparam logic [2:0] ROL = 3'b100;
    localparam logic [2:0] PAS = 3'b111;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] A, B;
    logic       SRC_SEL;
    logic [2:0] ALU_FUN;
    logic [3:0] SHAMT;
    logic       Shift_Enable;
    logic       start, start2;
    logic       Busy, Busy2;
    logic [7:0] SHIFT_OUT, OUT2;
    logic       SHIFT_Flag, Flag2;
`ifdef SHIFT_CARRY_EN
    logic       CARRY_OUT, CARRY2;
`endif

    typedef struct {
        string      tag;
        logic [7:0] res;
        int         lat;
        logic       cy;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   busy_cnt;
    int   lat2;
    int   flg_cnt;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(8), .SHAMT_W(4), .STEP(1)) u_dut (
        .clk(clk), .RST(RST), .A(A), .B(B), .SRC_SEL(SRC_SEL), .ALU_FUN(ALU_FUN),
        .SHAMT(SHAMT), .Shift_Enable(Shift_Enable), .start(start), .Busy(Busy),
        .SHIFT_OUT(SHIFT_OUT),
`ifdef SHIFT_CARRY_EN
        .CARRY_OUT(CARRY_OUT),
`endif
        .SHIFT_Flag(SHIFT_Flag)
    );

    shift_unit_seq #(.WIDTH(8), .SHAMT_W(4), .STEP(2)) u_dut2 (
        .clk(clk), .RST(RST), .A(A), .B(B), .SRC_SEL(SRC_SEL), .ALU_FUN(ALU_FUN),
        .SHAMT(SHAMT), .Shift_Enable(Shift_Enable), .start(start2), .Busy(Busy2),
        .SHIFT_OUT(OUT2),
`ifdef SHIFT_CARRY_EN
        .CARRY_OUT(CARRY2),
`endif
        .SHIFT_Flag(Flag2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] fun, input logic [3:0] sh, input logic s2,
                          input logic [7:0] res, input int lat, input logic cy,
                          input string tag);
        exp_t e;
        SRC_SEL = sel; A = a; B = b; ALU_FUN = fun; SHAMT = sh;
        start = 1'b1; start2 = s2;
        e.tag = tag; e.res = res; e.lat = lat; e.cy = cy;
        sb.push_back(e);
        tick();
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic collect(input int base);
        exp_t e;
        int   lat;
        lat      = 0;
        lat2     = 0;
        busy_cnt = Busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (Flag2 && lat2 == 0) lat2 = base + i;
            if (SHIFT_Flag) begin
                lat = base + i;
                break;
            end
            if (Busy) busy_cnt++;
        end
        e = sb.pop_front();
        check({e.tag, "_lat"}, lat, e.lat);
        check({e.tag, "_res"}, SHIFT_OUT, e.res);
`ifdef SHIFT_CARRY_EN
        check({e.tag, "_cy"}, CARRY_OUT, e.cy);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; Shift_Enable = 1'b1; start = 1'b0; start2 = 1'b0;
        A = '0; B = '0; SRC_SEL = 1'b0; ALU_FUN = '0; SHAMT = '0;
        tick(); tick();
        RST = 1'b0;
        check("rst_out", SHIFT_OUT, 8'h00);
        check("rst_flag", SHIFT_Flag, 1'b0);
        check("rst_busy", Busy, 1'b0);
`ifdef SHIFT_CARRY_EN
        check("rst_cy", CARRY_OUT, 1'b0);
`endif
        tick();

        launch(1'b0, 8'h28, 8'h00, LSR, 4'd1, 1'b0, 8'h14, 2, 1'b0, "lsr1");
        collect(0);
`ifdef SHIFT_CARRY_EN
        launch(1'b0, 8'h29, 8'h00, LSR, 4'd1, 1'b0, 8'h14, 2, 1'b1, "lsr1_cy");
        collect(0);
`endif

        launch(1'b1, 8'h00, 8'h81, ASR, 4'd3, 1'b1, 8'hF0, 4, 1'b0, "asr3");
        check("flag_one_cycle", SHIFT_Flag, 1'b0);
        B = 8'h00;
        collect(0);
        check("asr3_busy_cycles", busy_cnt, 3);
        check("asr3_step2_lat", lat2, 3);
        check("asr3_step2_res", OUT2, 8'hF0);

        launch(1'b0, 8'h96, 8'h00, ROL, 4'd11, 1'b0, 8'hB4, 4, 1'b0, "rol11");
        collect(0);
        launch(1'b0, 8'h96, 8'h00, LSL, 4'd9, 1'b0, 8'h00, 9, 1'b0, "lsl9");
        collect(0);
        launch(1'b0, 8'h96, 8'h00, PAS, 4'd5, 1'b0, 8'h96, 1, 1'b0, "pass");
        collect(0);

        launch(1'b0, 8'hF0, 8'h00, LSR, 4'd4, 1'b0, 8'h0F, 5, 1'b0, "lsr4_repulse");
        A = 8'h55; ALU_FUN = LSL; SHAMT = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        collect(1);

        launch(1'b0, 8'h01, 8'h00, ROR, 4'd1, 1'b0, 8'h80, 4, 1'b1, "ror1_en");
        Shift_Enable = 1'b0;
        tick(); tick();
        check("en_low_flag", SHIFT_Flag, 1'b0);
        check("en_low_busy", Busy, 1'b1);
        Shift_Enable = 1'b1;
        collect(2);
        Shift_Enable = 1'b0;
        #1;
        check("pend_low0", SHIFT_Flag, 1'b0);
        tick();
        check("pend_low1", SHIFT_Flag, 1'b0);
        Shift_Enable = 1'b1;
        #1;
        check("pend_issue", SHIFT_Flag, 1'b1);
        tick();
        check("pend_clear", SHIFT_Flag, 1'b0);

        SRC_SEL = 1'b0; A = 8'hFF; ALU_FUN = LSL; SHAMT = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_out", SHIFT_OUT, 8'h00);
        check("abort_busy", Busy, 1'b0);
        check("abort_flag", SHIFT_Flag, 1'b0);
`ifdef SHIFT_CARRY_EN
        check("abort_cy", CARRY_OUT, 1'b0);
`endif
        flg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (SHIFT_Flag) flg_cnt++;
        end
        check("abort_noflag", flg_cnt, 0);

        launch(1'b0, 8'hFF, 8'h00, LSL, 4'd5, 1'b0, 8'hE0, 6, 1'b1, "lsl5_after_rst");
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
